stage_sequencer: RTL

Per-window stage controller for the cascade classifier. For each accepted detection window it walks stages 0..N_STAGES-1. For every stage it:
- tells the feature evaluator which stage to accumulate;
- fetches that stage's threshold through the `stageThreshold` lookup;
- compares the returned stage sum against the threshold.

The window is rejected at the first failing stage, or reported as detected after the last stage passes. It sits between the window scanner (upstream), the feature evaluator and `stageThreshold` (side ports), and the detection collector (downstream).

---
 rtl/stage_seq_pkg.sv | 34 +++
 rtl/dreg.sv | 21 ++
 rtl/stage_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/stage_seq_pkg.sv
// Shared types and helpers for the cascade stage sequencer.
// Holds the FSM state encoding and the threshold sign-extension helper.
package stage_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CMP,
    ST_RESULT
  } stage_seq_state_t;

  localparam int SEXT_W = 64;

  // Widths are module parameters, so the helper works on a wide container:
  // bit w_data-1 of thr is replicated into every bit above it.
  function automatic logic [SEXT_W-1:0] sext_thr(input logic [SEXT_W-1:0] thr,
                                                 input int w_data);
    logic [SEXT_W-1:0] r;
    logic              msb;
    r   = '0;
    msb = 1'b0;
    for (int i = 0; i < SEXT_W; i++) begin
      if (i < w_data) begin
        r[i] = thr[i];
        msb  = thr[i];
      end else begin
        r[i] = msb;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dreg.sv
// Enabled data register with synchronous active-high reset.
// Used to hold the per-window result stable while it waits for the collector.
module dreg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Per-window stage controller for the cascade classifier: walks stages,
// issues stage/threshold requests, compares the stage sum and reports the result.
module stage_sequencer
  import stage_seq_pkg::*;
#(
  parameter int W_ADDR   = 5,
  parameter int W_DATA   = 11,
  parameter int W_SUM    = 16,
  parameter int N_STAGES = 25
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              win_valid,
  output logic              win_ready,

  output logic              stage_valid,
  input  logic              stage_ready,
  output logic [W_ADDR-1:0] stage_data,

  output logic              thr_addr_valid,
  input  logic              thr_addr_ready,
  output logic [W_ADDR-1:0] thr_addr_data,

  input  logic              thr_valid,
  output logic              thr_ready,
  input  logic [W_DATA-1:0] thr_data,

  input  logic              sum_valid,
  output logic              sum_ready,
  input  logic [W_SUM-1:0]  sum_data,

  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_detect,
  output logic [W_ADDR-1:0] res_stage
);

  localparam logic [W_ADDR-1:0] LAST_STAGE = W_ADDR'(N_STAGES - 1);

  stage_seq_state_t  st, st_n;
  logic [W_ADDR-1:0] s, s_n;
  logic [W_DATA-1:0] thr_q, thr_q_n;
  logic [W_SUM-1:0]  sum_q, sum_q_n;
  logic              thr_h, thr_h_n;
  logic              sum_h, sum_h_n;
  logic              stg_done, stg_done_n;
  logic              adr_done, adr_done_n;

  logic [W_SUM-1:0]  thr_sx;
  logic              stage_pass;
  logic              res_load;
  logic              res_detect_n;
  logic [W_ADDR:0]   res_bus;

  logic              in_capture;

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= ST_IDLE;
      s        <= '0;
      thr_q    <= '0;
      sum_q    <= '0;
      thr_h    <= 1'b0;
      sum_h    <= 1'b0;
      stg_done <= 1'b0;
      adr_done <= 1'b0;
    end else begin
      st       <= st_n;
      s        <= s_n;
      thr_q    <= thr_q_n;
      sum_q    <= sum_q_n;
      thr_h    <= thr_h_n;
      sum_h    <= sum_h_n;
      stg_done <= stg_done_n;
      adr_done <= adr_done_n;
    end
  end

  // Every handshake output is gated by rst so nothing transfers during reset.
  assign in_capture     = (st == ST_ISSUE) || (st == ST_WAIT);
  assign win_ready      = (st == ST_IDLE) && !rst;
  assign stage_valid    = (st == ST_ISSUE) && !stg_done && !rst;
  assign thr_addr_valid = (st == ST_ISSUE) && !adr_done && !rst;
  assign thr_ready      = in_capture && !thr_h && !rst;
  assign sum_ready      = in_capture && !sum_h && !rst;
  assign res_valid      = (st == ST_RESULT) && !rst;
  assign stage_data     = s;
  assign thr_addr_data  = s;

  assign thr_sx     = W_SUM'(sext_thr(SEXT_W'(thr_q), W_DATA));
  assign stage_pass = $signed(sum_q) >= $signed(thr_sx);

  always_comb begin
    st_n         = st;
    s_n          = s;
    thr_q_n      = thr_q;
    sum_q_n      = sum_q;
    thr_h_n      = thr_h;
    sum_h_n      = sum_h;
    stg_done_n   = stg_done;
    adr_done_n   = adr_done;
    res_load     = 1'b0;
    res_detect_n = 1'b0;

    if (thr_valid && thr_ready) begin
      thr_q_n = thr_data;
      thr_h_n = 1'b1;
    end
    if (sum_valid && sum_ready) begin
      sum_q_n = sum_data;
      sum_h_n = 1'b1;
    end

    case (st)
      ST_IDLE: begin
        if (win_valid && win_ready) begin
          st_n       = ST_ISSUE;
          s_n        = '0;
          thr_h_n    = 1'b0;
          sum_h_n    = 1'b0;
          stg_done_n = 1'b0;
          adr_done_n = 1'b0;
        end
      end
      ST_ISSUE: begin
        if (stage_valid && stage_ready) stg_done_n = 1'b1;
        if (thr_addr_valid && thr_addr_ready) adr_done_n = 1'b1;
        if (stg_done_n && adr_done_n) st_n = ST_WAIT;
      end
      ST_WAIT: begin
        // Captures landing this cycle count, keeping the best case at one WAIT cycle.
        if (thr_h_n && sum_h_n && stg_done && adr_done) st_n = ST_CMP;
      end
      ST_CMP: begin
        if (!stage_pass || (s == LAST_STAGE)) begin
          res_load     = 1'b1;
          res_detect_n = stage_pass;
          st_n         = ST_RESULT;
        end else begin
          s_n        = s + 1'b1;
          thr_h_n    = 1'b0;
          sum_h_n    = 1'b0;
          stg_done_n = 1'b0;
          adr_done_n = 1'b0;
          st_n       = ST_ISSUE;
        end
      end
      ST_RESULT: begin
        if (res_valid && res_ready) st_n = ST_IDLE;
      end
      default: st_n = ST_IDLE;
    endcase
  end

  dreg #(
    .W (W_ADDR + 1)
  ) u_res_reg (
    .clk (clk),
    .rst (rst),
    .en  (res_load),
    .d   ({res_detect_n, s}),
    .q   (res_bus)
  );

  assign {res_detect, res_stage} = res_bus;

endmodule
